// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the register-file write path.
//   REG_ADDR_W : register address width
//   DATA_W     : register data width
//   REG_ZERO   : the hardwired-zero register address
//   wb_req_t   : one register-file write request {we, addr, data}; used by
//                the pipeline source, the long-latency source and the
//                register-file port.
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
// DEPTH-entry circular buffer holding long-latency results until the
// register-file write port is free. The head entry is presented
// combinationally so it can be written in the same cycle it is selected.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_reg/data   enqueue request (ignored when full)
//   pop                   dequeue request (ignored when empty)
//   head_reg, head_data   oldest entry
//   full, empty           occupancy flags, from the count at cycle start
// ---------------------------------------------------------------------------
module wb_result_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_reg,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_reg,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] reg_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   assign head_reg  = reg_mem[rd_ptr_q];
   assign head_data = data_mem[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         reg_mem[wr_ptr_q]  <= push_reg;
         data_mem[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
// Sole driver of the register file's write port. Merges the in-order
// pipeline WB stage (always wins) with out-of-order long-latency results
// queued in a FIFO, tracks pending long-latency destinations and flags
// decode-stage read hazards on them.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   wb_reg_write/write_reg/data    pipeline WB request
//   ml_issue, ml_issue_reg         long-latency issue; ml_issue_ready out
//   ml_res_valid/reg/data          long-latency result; ml_res_ready out
//   read_reg1, read_reg2           decode read addresses; raw_stall out
//   pipe_bubble_req                ask the pipeline for a WB bubble
//   rf_reg_write/write_reg/data    register-file write port
// ---------------------------------------------------------------------------
module writeback_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_reg_write,
   input  logic [ADDR_W-1:0] wb_write_reg,
   input  logic [DATA_W-1:0] wb_write_data,
   input  logic              ml_issue,
   input  logic [ADDR_W-1:0] ml_issue_reg,
   output logic              ml_issue_ready,
   input  logic              ml_res_valid,
   input  logic [ADDR_W-1:0] ml_res_reg,
   input  logic [DATA_W-1:0] ml_res_data,
   output logic              ml_res_ready,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic              raw_stall,
   output logic              pipe_bubble_req,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data
);

   import mips_pkg::wb_req_t;
   import mips_pkg::REG_ZERO;

   localparam int NREG  = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [NREG-1:0]   pending_q, pending_d;
   logic [CNT_W-1:0]  starve_q,  starve_d;
   logic              bubble_q,  bubble_d;

   logic              fifo_full, fifo_empty, fifo_pop;
   logic [ADDR_W-1:0] head_reg;
   logic [DATA_W-1:0] head_data;
   logic              wb_win;
   wb_req_t           rf_req;

   wb_result_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ml_res_valid),
      .push_reg  (ml_res_reg),
      .push_data (ml_res_data),
      .pop       (fifo_pop),
      .head_reg  (head_reg),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A pipeline write to reg 0 is a no-op and leaves the port to the FIFO.
   assign wb_win   = wb_reg_write && (wb_write_reg != REG_ZERO);
   assign fifo_pop = !wb_win && !fifo_empty;

   always_comb begin
      rf_req = '0;
      if (wb_win) begin
         rf_req.we   = 1'b1;
         rf_req.addr = wb_write_reg;
         rf_req.data = wb_write_data;
      end else if (!fifo_empty) begin
         rf_req.we   = (head_reg != REG_ZERO);
         rf_req.addr = head_reg;
         rf_req.data = head_data;
      end
   end

   assign rf_reg_write  = rf_req.we;
   assign rf_write_reg  = rf_req.addr;
   assign rf_write_data = rf_req.data;

   assign ml_res_ready    = !fifo_full;
   assign ml_issue_ready  = !pending_q[ml_issue_reg];
   // Pending is cleared only at the posedge after the commit, so the stall
   // covers the pop cycle itself.
   assign raw_stall       = pending_q[read_reg1] | pending_q[read_reg2];
   assign pipe_bubble_req = bubble_q;

   always_comb begin
      pending_d = pending_q;
      if (fifo_pop && head_reg != REG_ZERO)
         pending_d[head_reg] = 1'b0;
      if (ml_issue && ml_issue_ready)
         pending_d[ml_issue_reg] = 1'b1;
      pending_d[0] = 1'b0;

      starve_d = starve_q;
      if (fifo_empty || fifo_pop)
         starve_d = '0;
      else if (starve_q != STARVE_MAX)
         starve_d = starve_q + 1'b1;

      bubble_d = (starve_d == STARVE_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         starve_q  <= '0;
         bubble_q  <= 1'b0;
      end else begin
         pending_q <= pending_d;
         starve_q  <= starve_d;
         bubble_q  <= bubble_d;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        ml_issue;
   logic [4:0]  ml_issue_reg;
   logic        ml_issue_ready;
   logic        ml_res_valid;
   logic [4:0]  ml_res_reg;
   logic [31:0] ml_res_data;
   logic        ml_res_ready;
   logic [4:0]  read_reg1, read_reg2;
   logic        raw_stall;
   logic        pipe_bubble_req;
   logic        rf_reg_write;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;

   writeback_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .wb_reg_write    (wb_reg_write),
      .wb_write_reg    (wb_write_reg),
      .wb_write_data   (wb_write_data),
      .ml_issue        (ml_issue),
      .ml_issue_reg    (ml_issue_reg),
      .ml_issue_ready  (ml_issue_ready),
      .ml_res_valid    (ml_res_valid),
      .ml_res_reg      (ml_res_reg),
      .ml_res_data     (ml_res_data),
      .ml_res_ready    (ml_res_ready),
      .read_reg1       (read_reg1),
      .read_reg2       (read_reg2),
      .raw_stall       (raw_stall),
      .pipe_bubble_req (pipe_bubble_req),
      .rf_reg_write    (rf_reg_write),
      .rf_write_reg    (rf_write_reg),
      .rf_write_data   (rf_write_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: results queue, pending set, starvation count, reg file.
   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;
   ent_t        mq[$];
   bit   [31:0] mpend;
   int          mstarve;
   logic [31:0] mrf [32];
   bit          last_push;
   logic [4:0]  fifo_log[$];

   task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b @%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(string name);
      checks++;
      failures++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   task automatic idle();
      wb_reg_write  = 1'b0;
      wb_write_reg  = '0;
      wb_write_data = '0;
      ml_issue      = 1'b0;
      ml_issue_reg  = '0;
      ml_res_valid  = 1'b0;
      ml_res_reg    = '0;
      ml_res_data   = '0;
      read_reg1     = '0;
      read_reg2     = '0;
   endtask

   task automatic model_reset();
      mq.delete();
      mpend   = '0;
      mstarve = 0;
   endtask

   // One clock: compare all outputs against the model at negedge, then
   // advance the model and move to just after the next posedge.
   task automatic step();
      bit          win, pop, push, issue_ok;
      logic        ew;
      logic [4:0]  er;
      logic [31:0] ed;
      @(negedge clk);
      win = wb_reg_write && (wb_write_reg != 5'd0);
      ew = 1'b0; er = '0; ed = '0;
      if (win) begin
         ew = 1'b1; er = wb_write_reg; ed = wb_write_data;
      end else if (mq.size() > 0) begin
         ew = (mq[0].r != 5'd0); er = mq[0].r; ed = mq[0].d;
      end
      chk1 ("rf_reg_write", rf_reg_write, ew);
      chk32("rf_write_reg", 32'(rf_write_reg), 32'(er));
      chk32("rf_write_data", rf_write_data, ed);
      chk1 ("ml_res_ready", ml_res_ready, mq.size() < DEPTH);
      chk1 ("ml_issue_ready", ml_issue_ready, !mpend[ml_issue_reg]);
      chk1 ("raw_stall", raw_stall, mpend[read_reg1] | mpend[read_reg2]);
      chk1 ("pipe_bubble_req", pipe_bubble_req, mstarve == LIMIT);
      if (rf_reg_write && !win) fifo_log.push_back(rf_write_reg);

      pop      = !win && mq.size() > 0;
      push     = ml_res_valid && mq.size() < DEPTH;
      issue_ok = ml_issue && !mpend[ml_issue_reg] && ml_issue_reg != 5'd0;
      if (ew) mrf[er] = ed;
      if (mq.size() == 0 || pop) mstarve = 0;
      else if (mstarve < LIMIT) mstarve++;
      if (pop) begin
         if (mq[0].r != 5'd0) mpend[mq[0].r] = 1'b0;
         void'(mq.pop_front());
      end
      if (issue_ok) mpend[ml_issue_reg] = 1'b1;
      if (push) mq.push_back('{r: ml_res_reg, d: ml_res_data});
      last_push = push;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(string name);
      int n = 0;
      idle();
      while (mq.size() > 0 && n < 40) begin
         step();
         n++;
      end
      if (mq.size() > 0) timeout(name);
   endtask

   initial begin
      idle();
      model_reset();
      foreach (mrf[i]) mrf[i] = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      // Reset state
      chk1("reset_rf_reg_write", rf_reg_write, 1'b0);
      chk1("reset_ml_res_ready", ml_res_ready, 1'b1);
      chk1("reset_ml_issue_ready", ml_issue_ready, 1'b1);
      chk1("reset_raw_stall", raw_stall, 1'b0);
      chk1("reset_bubble", pipe_bubble_req, 1'b0);

      // Pipeline pass-through, and reg-0 write is no write
      wb_reg_write = 1'b1; wb_write_reg = 5'd8; wb_write_data = 32'hDEADBEEF;
      #1;
      chk1 ("pass_we", rf_reg_write, 1'b1);
      chk32("pass_reg", 32'(rf_write_reg), 32'd8);
      chk32("pass_data", rf_write_data, 32'hDEADBEEF);
      step();
      wb_write_reg = 5'd0; wb_write_data = 32'h12345678;
      #1;
      chk1("reg0_we", rf_reg_write, 1'b0);
      step();

      // Scoreboard on reg 12
      idle();
      ml_issue = 1'b1; ml_issue_reg = 5'd12;
      step();
      idle();
      read_reg2 = 5'd12;
      repeat (4) begin
         #1 chk1("sb_stall_wait", raw_stall, 1'b1);
         step();
      end
      ml_res_valid = 1'b1; ml_res_reg = 5'd12; ml_res_data = 32'h0000CAFE;
      ml_issue = 1'b1; ml_issue_reg = 5'd12;
      #1;
      chk1("sb_reissue_ready", ml_issue_ready, 1'b0);
      chk1("sb_stall_arrive", raw_stall, 1'b1);
      step();
      ml_res_valid = 1'b0; ml_issue = 1'b0;
      #1;
      chk1 ("sb_pop_we", rf_reg_write, 1'b1);
      chk32("sb_pop_reg", 32'(rf_write_reg), 32'd12);
      chk1 ("sb_stall_pop", raw_stall, 1'b1);
      step();
      #1 chk1("sb_stall_after", raw_stall, 1'b0);
      step();

      // Collision: FIFO result for reg 3 while pipeline writes reg 4
      idle();
      wb_reg_write = 1'b1; wb_write_reg = 5'd4; wb_write_data = 32'h22;
      ml_res_valid = 1'b1; ml_res_reg = 5'd3; ml_res_data = 32'h11;
      #1 chk32("coll_first_reg", 32'(rf_write_reg), 32'd4);
      step();
      idle();
      #1;
      chk32("coll_second_reg", 32'(rf_write_reg), 32'd3);
      chk32("coll_second_data", rf_write_data, 32'h11);
      step();
      chk32("coll_model_r3", mrf[3], 32'h11);
      chk32("coll_model_r4", mrf[4], 32'h22);

      // FIFO full while the pipeline writes every cycle
      idle();
      wb_reg_write = 1'b1; wb_write_reg = 5'd20;
      for (int i = 0; i < 4; i++) begin
         wb_write_data = $urandom;
         ml_res_valid = 1'b1; ml_res_reg = 5'(21 + i); ml_res_data = $urandom;
         step();
      end
      ml_res_valid = 1'b0;
      #1;
      chk1("full_ready", ml_res_ready, 1'b0);
      chk1("full_bubble", pipe_bubble_req, 1'b1);
      step();
      wb_reg_write = 1'b0;
      step();
      #1;
      chk1("bubble_ready", ml_res_ready, 1'b1);
      chk1("bubble_cleared", pipe_bubble_req, 1'b0);
      ml_res_valid = 1'b1; ml_res_reg = 5'd25; ml_res_data = 32'h25;
      step();
      wb_reg_write = 1'b1; ml_res_reg = 5'd26; ml_res_data = 32'h26;
      step();
      #1 chk1("refill_ready", ml_res_ready, 1'b0);
      drain("full_drain");

      // Reset mid-run with two queued entries and reg 5 pending
      idle();
      ml_issue = 1'b1; ml_issue_reg = 5'd5;
      step();
      idle();
      wb_reg_write = 1'b1; wb_write_reg = 5'd20;
      ml_res_valid = 1'b1; ml_res_reg = 5'd7; ml_res_data = 32'h7;
      step();
      ml_res_reg = 5'd9; ml_res_data = 32'h9;
      step();
      idle();
      read_reg1 = 5'd5; ml_issue_reg = 5'd5;
      #1 chk1("prereset_stall", raw_stall, 1'b1);
      rst = 1'b1;
      #1;
      chk1 ("rst_ml_res_ready", ml_res_ready, 1'b1);
      chk1 ("rst_raw_stall", raw_stall, 1'b0);
      chk1 ("rst_issue_ready", ml_issue_ready, 1'b1);
      chk1 ("rst_rf_we", rf_reg_write, 1'b0);
      chk32("rst_rf_reg", 32'(rf_write_reg), 32'd0);
      chk1 ("rst_bubble", pipe_bubble_req, 1'b0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // Wrap-around: issue regs 1..10, then results in order
      idle();
      for (int k = 1; k <= 10; k++) begin
         ml_issue = 1'b1; ml_issue_reg = 5'(k);
         step();
      end
      idle();
      fifo_log.delete();
      for (int k = 1; k <= 10; k++) begin
         int n = 0;
         ml_res_valid = 1'b1; ml_res_reg = 5'(k); ml_res_data = 32'(k * 32'h101);
         do begin
            wb_reg_write  = 1'($urandom_range(0, 1));
            wb_write_reg  = 5'($urandom_range(20, 30));
            wb_write_data = $urandom;
            step();
            n++;
         end while (!last_push && n < 50);
         if (!last_push) timeout("wrap_push");
      end
      drain("wrap_drain");
      chk32("wrap_count", 32'(fifo_log.size()), 32'd10);
      for (int i = 0; i < 10 && i < fifo_log.size(); i++)
         chk32("wrap_order", 32'(fifo_log[i]), 32'(i + 1));
      for (int k = 1; k <= 10; k++) begin
         read_reg1 = 5'(k);
         #1 chk1("wrap_pending_clear", raw_stall, 1'b0);
      end
      step();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         logic [4:0] r;
         wb_reg_write  = 1'($urandom_range(0, 1));
         wb_write_reg  = 5'($urandom);
         wb_write_data = $urandom;
         ml_issue      = ($urandom_range(0, 3) == 0);
         ml_issue_reg  = 5'($urandom);
         ml_res_valid  = ($urandom_range(0, 2) == 0);
         r = 5'($urandom);
         for (int t = 0; t < 8; t++) begin
            if (mpend[r]) break;
            r = 5'($urandom);
         end
         ml_res_reg    = r;
         ml_res_data   = $urandom;
         read_reg1     = 5'($urandom);
         read_reg2     = 5'($urandom);
         step();
      end
      drain("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Sole driver of the register file's single write port (write_reg / write_data / reg_write).
- Merges two result sources:
  - pipeline WB stage: in-order, never waits;
  - long-latency mult/div unit: out-of-order completions, held in a small FIFO.
- Keeps a pending-destination scoreboard and flags read hazards on the decode-stage read addresses, so decode stalls until long-latency results are in the register file.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 4, long-latency result FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 3, consecutive blocked cycles with FIFO non-empty before pipe_bubble_req asserts

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- wb_reg_write  in  1  pipeline WB write enable
- wb_write_reg  in  ADDR_W  pipeline WB destination
- wb_write_data  in  DATA_W  pipeline WB data
- ml_issue  in  1  long-latency op issued this cycle (effective only when ml_issue_ready)
- ml_issue_reg  in  ADDR_W  destination of the issued op
- ml_issue_ready  out  1  issue accepted: destination not already pending
- ml_res_valid  in  1  long-latency result valid
- ml_res_reg  in  ADDR_W  result destination
- ml_res_data  in  DATA_W  result data
- ml_res_ready  out  1  FIFO not full
- read_reg1, read_reg2  in  ADDR_W  decode-stage read addresses
- raw_stall  out  1  a read address is pending
- pipe_bubble_req  out  1  request one WB bubble to drain FIFO
- rf_reg_write  out  1  to register-file reg_write
- rf_write_reg  out  ADDR_W  to register-file write_reg
- rf_write_data  out  DATA_W  to register-file write_data

Behaviour:
- Write-port mux is combinational, so the register file (negedge write) commits in the same cycle as the input; zero added WB latency.
- Source selection, in priority order:
  - wb_reg_write=1 and wb_write_reg≠0: pipeline wins; rf_* = wb_*.
  - Otherwise, FIFO non-empty: rf_* = head entry, rf_reg_write=1 only if head reg≠0; head pops at next posedge.
  - Otherwise: rf_reg_write=0, rf_write_reg=0, rf_write_data=0.
- A pipeline write to reg 0 is treated as no write and frees the slot for the FIFO.
- FIFO:
  - ml_res_ready = !full, using count at cycle start.
  - Push when ml_res_valid && ml_res_ready.
  - Push and pop in the same cycle are allowed; count unchanged.
  - Pointers wrap modulo DEPTH.
  - An entry with reg 0 is popped but not written.
- Scoreboard (pending[31:0]):
  - pending[0] is hardwired 0.
  - ml_issue_ready = !pending[ml_issue_reg]. Issue to reg 0 is always ready and sets nothing.
  - Set: ml_issue && ml_issue_ready.
  - Clear: the cycle a FIFO entry with that reg is written to the register file.
  - Set and clear of the same reg in one cycle cannot occur (issue rejected while pending).
- raw_stall = pending[read_reg1] | pending[read_reg2], combinational. The result is visible to a same-cycle register-file read only after its negedge commit, so raw_stall stays high through the cycle of the clearing pop and falls the cycle after.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the pipeline wins.
  - Resets to 0 on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - pipe_bubble_req = (counter == STARVE_LIMIT), registered.
- Reset (asynchronous, any time): FIFO empty, pointers 0, pending all 0, counter 0, pipe_bubble_req=0. After reset: ml_res_ready=1, ml_issue_ready=1, raw_stall=0, rf_* follow the mux (all 0 when idle). In-flight results are discarded; the mult/div unit is reset by the same rst.

Decomposition:
- Shared package mips_pkg: REG_ADDR_W=5, DATA_W=32, REG_ZERO constant, typedef wb_req_t {we, addr, data}, used by both sources and the rf port.
- One sub-module: wb_result_fifo (DEPTH-entry circular buffer with push/pop/full/empty/count).
- Scoreboard, mux and starvation counter stay in the top module.

Test Plan:
- Reset: assert rst mid-run with FIFO holding 2 entries and pending[5]=1 → all outputs return to reset values immediately; ml_res_ready=1; raw_stall=0 for read_reg1=5.
- Pipeline pass-through: wb write reg 8 = 0xDEADBEEF → rf_reg_write=1, rf_write_reg=8, data 0xDEADBEEF the same cycle; a write to reg 0 gives rf_reg_write=0.
- Scoreboard: issue reg 12, result arrives 5 cycles later into an idle pipeline → raw_stall=1 for read_reg2=12 until the pop cycle, 0 the cycle after; a second issue to reg 12 while pending gives ml_issue_ready=0.
- Collision: result for reg 3 (0x11) arrives with the pipeline writing reg 4 (0x22) → reg 4 written that cycle, reg 3 written the next idle cycle; final values reg3=0x11, reg4=0x22.
- FIFO full: 4 results pushed while the pipeline writes every cycle → ml_res_ready=0 after the 4th; pipe_bubble_req=1 after 3 blocked cycles; one bubble pops one entry; push+pop in the same cycle keeps count at 4.
- Wrap-around: 10 sequential results to regs 1..10 with random WB conflicts → all written in FIFO order, pending returns to 0, pointers wrap correctly.
